// File: rtl/cis_line_capture.sv
// cis_line_capture: synchronises the divider's CIS clock, issues the start-of-line pulse, skips dummy pixels and captures one ADC sample per CIS period (CIS_LINE_SUM_EN adds a per-line sample sum).
// Latency: cis_rise 2-3 clk_in after a real CIS edge; sample taken SAMPLE_DLY cycles after cis_rise, pix_valid/pix_data the cycle after.
// Backpressure: none; the pixel stream is strobe-only and start is ignored while a line is in progress.
module cis_line_capture #(
    parameter int          ADC_W      = 12,
    parameter logic [15:0] PIX_NUM    = 16'd2592,
    parameter logic [7:0]  DUMMY_PIX  = 8'd16,
    parameter logic [3:0]  SAMPLE_DLY = 4'd3
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             cis_clk,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             start,
    output logic             cis_si,
    output logic             busy,
    output logic             pix_valid,
    output logic [ADC_W-1:0] pix_data,
    output logic [15:0]      pix_index,
    output logic             line_done
`ifdef CIS_LINE_SUM_EN
    ,
    output logic [ADC_W+15:0] line_sum,
    output logic              line_sum_valid
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SI,
        ST_SKIP,
        ST_WAIT,
        ST_CAPT,
        ST_DONE
    } state_t;

    localparam bit DLY_ZERO = (SAMPLE_DLY == 4'd0);

    state_t      state;
    state_t      state_nxt;
    state_t      first_tgt;
    logic        cis_sync1;
    logic        cis_sync2;
    logic        cis_hist;
    logic        cis_rise;
    logic [7:0]  skip_cnt;
    logic        skip_hit;
    logic [3:0]  dly_cnt;
    logic [4:0]  dly_cnt_inc;
    logic        dly_hit;
    logic        dly_run;
    logic [15:0] pix_cnt;
    logic        last_pix;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cis_sync1 <= 1'b0;
            cis_sync2 <= 1'b0;
            cis_hist  <= 1'b0;
        end else begin
            cis_sync1 <= cis_clk;
            cis_sync2 <= cis_sync1;
            cis_hist  <= cis_sync2;
        end
    end

    assign cis_rise = cis_sync2 & ~cis_hist;

    // The incremented count is compared so the sample lands exactly SAMPLE_DLY cycles after the rise.
    assign dly_cnt_inc = {1'b0, dly_cnt} + 5'd1;
    assign dly_hit     = (dly_cnt_inc == {1'b0, SAMPLE_DLY});
    assign skip_hit    = (({1'b0, skip_cnt} + 9'd1) == {1'b0, DUMMY_PIX});
    assign last_pix    = (pix_cnt == (PIX_NUM - 16'd1));
    assign first_tgt   = DLY_ZERO ? ST_CAPT : ST_WAIT;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_ARM;
            ST_ARM:  if (cis_rise) state_nxt = ST_SI;
            ST_SI: begin
                if (cis_rise) begin
                    state_nxt = (DUMMY_PIX != 8'd0) ? ST_SKIP : first_tgt;
                end
            end
            ST_SKIP: if (cis_rise && skip_hit) state_nxt = first_tgt;
            // Before the delay runs, WAIT idles until the next rise; with zero delay that rise samples directly.
            ST_WAIT: begin
                if (dly_run ? dly_hit : (cis_rise && DLY_ZERO)) state_nxt = ST_CAPT;
            end
            ST_CAPT: state_nxt = last_pix ? ST_DONE : ST_WAIT;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cis_si    = (state == ST_SI);
        busy      = (state != ST_IDLE) && (state != ST_DONE);
        pix_valid = (state == ST_CAPT);
        line_done = (state == ST_DONE);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            skip_cnt  <= '0;
            dly_cnt   <= '0;
            dly_run   <= 1'b0;
            pix_cnt   <= '0;
            pix_data  <= '0;
            pix_index <= '0;
        end else begin
            if (state == ST_SI && cis_rise) begin
                skip_cnt <= '0;
            end else if (state == ST_SKIP && cis_rise) begin
                skip_cnt <= skip_cnt + 8'd1;
            end

            // Entry from SI/SKIP happens on a rise, so the delay starts at once; after a capture it waits.
            if (state != ST_WAIT && state_nxt == ST_WAIT) begin
                dly_cnt <= '0;
                dly_run <= (state != ST_CAPT);
            end else if (state == ST_WAIT) begin
                if (dly_run) begin
                    dly_cnt <= dly_cnt + 4'd1;
                end else if (cis_rise) begin
                    dly_run <= 1'b1;
                    dly_cnt <= '0;
                end
            end

            if (state == ST_IDLE && state_nxt == ST_ARM) begin
                pix_cnt <= '0;
            end else if (state == ST_CAPT) begin
                pix_cnt <= pix_cnt + 16'd1;
            end

            if (state_nxt == ST_CAPT) begin
                pix_data  <= adc_data;
                pix_index <= pix_cnt;
            end
        end
    end

`ifdef CIS_LINE_SUM_EN
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            line_sum <= '0;
        end else if (state == ST_IDLE && state_nxt == ST_ARM) begin
            line_sum <= '0;
        end else if (pix_valid) begin
            line_sum <= line_sum + {16'd0, pix_data};
        end
    end

    always_comb begin
        line_sum_valid = (state == ST_DONE);
    end
`endif

endmodule

// File: tb/tb_cis_line_capture.sv
// Directed bench for cis_line_capture: two instances (2 dummies/delay 3 and 0 dummies/delay 0) share stimulus.
// CIS clock is driven synchronously (10 clk_in period) so strobe timing and sampled data are exact.
module tb_cis_line_capture;

    logic        clk_in   = 1'b0;
    logic        reset_n  = 1'b0;
    logic        cis_clk  = 1'b0;
    logic [11:0] adc_data = '0;
    logic        start_a  = 1'b0;
    logic        start_b  = 1'b0;

    logic        si_a, bz_a, pv_a, ld_a, si_b, bz_b, pv_b, ld_b;
    logic [11:0] pd_a, pd_b;
    logic [15:0] pi_a, pi_b;
`ifdef CIS_LINE_SUM_EN
    logic [27:0] ls_a, ls_b;
    logic        lsv_a, lsv_b;
`endif

    cis_line_capture #(.ADC_W(12), .PIX_NUM(16'd8), .DUMMY_PIX(8'd2), .SAMPLE_DLY(4'd3)) dut_a (
        .clk_in(clk_in), .reset_n(reset_n), .cis_clk(cis_clk), .adc_data(adc_data), .start(start_a),
        .cis_si(si_a), .busy(bz_a), .pix_valid(pv_a), .pix_data(pd_a), .pix_index(pi_a), .line_done(ld_a)
`ifdef CIS_LINE_SUM_EN
        , .line_sum(ls_a), .line_sum_valid(lsv_a)
`endif
    );

    cis_line_capture #(.ADC_W(12), .PIX_NUM(16'd8), .DUMMY_PIX(8'd0), .SAMPLE_DLY(4'd0)) dut_b (
        .clk_in(clk_in), .reset_n(reset_n), .cis_clk(cis_clk), .adc_data(adc_data), .start(start_b),
        .cis_si(si_b), .busy(bz_b), .pix_valid(pv_b), .pix_data(pd_b), .pix_index(pi_b), .line_done(ld_b)
`ifdef CIS_LINE_SUM_EN
        , .line_sum(ls_b), .line_sum_valid(lsv_b)
`endif
    );

    int          tests = 0;
    int          fails = 0;
    bit          sel = 1'b0;
    bit          cis_run = 1'b0;
    int          cis_tok = 0;
    bit          data_mode = 1'b0;
    logic [11:0] const_val = '0;

    logic        si, bz, pv, ld;
    logic [11:0] pd;
    logic [15:0] pi;
`ifdef CIS_LINE_SUM_EN
    logic [27:0] ls;
    logic        lsv;
`endif

    always_comb begin
        si = sel ? si_b : si_a;
        bz = sel ? bz_b : bz_a;
        pv = sel ? pv_b : pv_a;
        ld = sel ? ld_b : ld_a;
        pd = sel ? pd_b : pd_a;
        pi = sel ? pi_b : pi_a;
`ifdef CIS_LINE_SUM_EN
        ls  = sel ? ls_b : ls_a;
        lsv = sel ? lsv_b : lsv_a;
`endif
    end

    initial forever #5 clk_in = ~clk_in;

    // CIS clock: rise number n (counted from each restart) sets adc_data to 100+n.
    initial begin
        int ph;
        int edge_n;
        int seen_tok;
        ph = 0;
        edge_n = 0;
        seen_tok = 0;
        forever begin
            @(posedge clk_in);
            #1;
            if (cis_tok != seen_tok) begin
                seen_tok = cis_tok;
                ph = 0;
                edge_n = 0;
            end
            if (!cis_run) begin
                cis_clk = 1'b0;
            end else begin
                if (ph == 0) begin
                    cis_clk = 1'b1;
                    edge_n++;
                    adc_data = data_mode ? const_val : 12'(100 + edge_n);
                end else if (ph == 5) begin
                    cis_clk = 1'b0;
                end
                ph = (ph == 9) ? 0 : ph + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic do_start(input string tag);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, "_busy_after_start"}, bz, 1'b1);
    endtask

    // Stop the CIS clock, accept a start, then restart the CIS clock from rise 1.
    task automatic begin_line(input string tag);
        cis_run = 1'b0;
        repeat (5) tick();
        do_start(tag);
        cis_tok++;
        cis_run = 1'b1;
    endtask

    // Returns at the first cycle cis_si is low again.
    task automatic check_si(input string tag);
        int w;
        int width;
        w = 0;
        while (si !== 1'b1 && w < 200) begin tick(); w++; end
        chk({tag, "_si_seen"}, si, 1'b1);
        if (si !== 1'b1) return;
        width = 0;
        while (si === 1'b1 && width < 50) begin tick(); width++; end
        chk({tag, "_si_width"}, width, 10);
    endtask

    task automatic check_line(input string tag, input int base, input int step, input bit chk_data,
                              input int first_dly, input int pulse_idx, input int exp_sum);
        int w;
        for (int k = 0; k < 8; k++) begin
            w = 0;
            while (pv !== 1'b1 && w < 300) begin tick(); w++; end
            chk({tag, "_strobe"}, pv, 1'b1);
            if (pv !== 1'b1) return;
            if (k == 0) begin
                if (first_dly >= 0) chk({tag, "_first_dly"}, w, first_dly);
            end else begin
                chk({tag, "_gap"}, w + 1, 10);
            end
            chk({tag, "_index"}, pi, k);
            if (chk_data) chk({tag, "_data"}, pd, base + k * step);
            if (k == pulse_idx) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            tick();
            start_a = 1'b0;
            start_b = 1'b0;
            if (k < 7) chk({tag, "_no_b2b"}, pv, 1'b0);
        end
        chk({tag, "_line_done"}, ld, 1'b1);
`ifdef CIS_LINE_SUM_EN
        chk({tag, "_sum_valid"}, lsv, 1'b1);
        if (exp_sum >= 0) chk({tag, "_sum"}, ls, exp_sum);
`endif
        tick();
        chk({tag, "_done_1cyc"}, ld, 1'b0);
        chk({tag, "_idle"}, bz, 1'b0);
        tick();
    endtask

    initial begin
        int n_pv;
        int n_ld;
        int n_si;
        int n_nb;
        int w;

        repeat (3) tick();
        chk("rst_si_a", si_a, 1'b0);
        chk("rst_busy_a", bz_a, 1'b0);
        chk("rst_pv_a", pv_a, 1'b0);
        chk("rst_ld_a", ld_a, 1'b0);
        chk("rst_pidx_a", pi_a, 16'd0);
        chk("rst_pdat_b", pd_b, 12'd0);
        chk("rst_busy_b", bz_b, 1'b0);
        reset_n = 1'b1;
        repeat (2) tick();

        sel = 1'b0;
        begin_line("basic");
        check_si("basic");
        check_line("basic", 104, 1, 1'b1, 23, -1, -1);
        n_pv = 0;
        repeat (30) begin tick(); if (pv === 1'b1) n_pv++; end
        chk("basic_no_extra", n_pv, 0);

        sel = 1'b1;
        begin_line("edge0");
        check_si("edge0");
        check_line("edge0", 102, 1, 1'b1, 0, -1, -1);

        sel = 1'b0;
        begin_line("busy");
        check_si("busy");
        check_line("busy", 104, 1, 1'b1, 23, 3, -1);
        do_start("restart");
        check_si("restart");
        check_line("restart", 0, 0, 1'b0, 23, -1, -1);

        begin_line("stall");
        cis_run = 1'b0;
        n_pv = 0; n_si = 0; n_nb = 0;
        repeat (60) begin
            tick();
            if (pv === 1'b1) n_pv++;
            if (si === 1'b1) n_si++;
            if (bz !== 1'b1) n_nb++;
        end
        chk("stall_no_pv", n_pv, 0);
        chk("stall_no_si", n_si, 0);
        chk("stall_busy_held", n_nb, 0);
        cis_tok++;
        cis_run = 1'b1;
        check_si("stall_resume");
        check_line("stall_resume", 104, 1, 1'b1, 23, -1, -1);

        begin_line("rst_skip");
        check_si("rst_skip");
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("rst_skip_si", si, 1'b0);
        chk("rst_skip_busy", bz, 1'b0);
        chk("rst_skip_pidx", pi, 16'd0);
        chk("rst_skip_pdat", pd, 12'd0);
        repeat (2) tick();
        chk("rst_skip_ld", ld, 1'b0);
        reset_n = 1'b1;
        n_pv = 0; n_ld = 0;
        repeat (40) begin
            tick();
            if (pv === 1'b1) n_pv++;
            if (ld === 1'b1 || bz !== 1'b0) n_ld++;
        end
        chk("rst_skip_quiet_pv", n_pv, 0);
        chk("rst_skip_idle", n_ld, 0);

        begin_line("rst_pix5");
        check_si("rst_pix5");
        w = 0;
        while (!(pv === 1'b1 && pi === 16'd5) && w < 400) begin tick(); w++; end
        chk("rst_pix5_reached", pi, 16'd5);
        reset_n = 1'b0;
        #1;
        chk("rst_pix5_pv", pv, 1'b0);
        chk("rst_pix5_busy", bz, 1'b0);
        chk("rst_pix5_pidx", pi, 16'd0);
        chk("rst_pix5_pdat", pd, 12'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        n_pv = 0; n_ld = 0;
        repeat (60) begin
            tick();
            if (pv === 1'b1) n_pv++;
            if (ld === 1'b1) n_ld++;
        end
        chk("rst_pix5_no_pv", n_pv, 0);
        chk("rst_pix5_no_ld", n_ld, 0);
        begin_line("after_rst");
        check_si("after_rst");
        check_line("after_rst", 104, 1, 1'b1, 23, -1, -1);

`ifdef CIS_LINE_SUM_EN
        data_mode = 1'b1;
        const_val = 12'hFFF;
        begin_line("sum_fff");
        check_si("sum_fff");
        check_line("sum_fff", 4095, 0, 1'b1, 23, -1, 32760);
        const_val = 12'd1;
        begin_line("sum_one");
        check_si("sum_one");
        check_line("sum_one", 1, 0, 1'b1, 23, -1, 8);
        data_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
